uart_tx_module: RTL and testbench
=================================

Name: uart_tx_module

Overview:
- Transmit-side UART block, the counterpart of the UART receive path.
- Accepts up to N bytes per cycle into an internal multi-push/single-pop FIFO (multi_push_multi_pop_fifo, W=8, NI=N, NO=1).
- A bit-timing FSM serialises each byte as an 8N1 frame (start bit, 8 data bits LSB-first, 1 stop bit) on tx.
- Sits between DSP/result logic and the board TX pin.

Parameters:
- clk_mhz, 50, system clock frequency in MHz.
- boadrate, 9600, line rate in bit/s; bit period scale = clk_mhz*1000*1000/boadrate cycles (integer division).
- DEPTH, 4, FIFO depth in bytes (DEPTH >= N).
- N, 4, maximum bytes accepted per push.

Ports:
- clk  input  1  system clock, all logic on posedge.
- arstn  input  1  reset; asynchronous, active-low.
- data  input  [N-1:0][7:0]  bytes to enqueue; data[0] is transmitted first.
- push  input  $clog2(N+1)  number of bytes of data to enqueue this cycle (0..N).
- can_push  output  $clog2(N+1)  min(free FIFO slots, N).
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.

Behaviour:
- Reset (arstn low, asynchronous, any time including mid-frame):
  - tx=1, busy=0, FSM=IDLE.
  - Bit counters cleared, FIFO emptied, can_push=min(DEPTH,N).
  - An in-progress frame is abandoned with no stop bit. After release, tx stays high until a new push.
- Push rules:
  - If push > can_push, the whole request is dropped (nothing enqueued, no partial write).
  - Otherwise data[0..push-1] are enqueued in index order.
  - can_push reflects state after the previous edge. A simultaneous FIFO pop does not raise can_push in the same cycle.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty, pop one byte into shift register, load bit counter = scale-1, go to START.
  - START: tx=0 for scale cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[bit index] for scale cycles per bit, indices 0..7. After index 7's period, go to STOP.
  - STOP: tx=1 for scale cycles. At the end: if FIFO non-empty, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Timing:
  - Bit counter counts down from scale-1. Bit boundary when counter==0, then reload scale-1.
  - Frame length is exactly 10*scale cycles.
  - Latency: a push at edge k into an empty FIFO with FSM in IDLE pops at edge k+1; tx goes low after edge k+1.
  - tx only changes at bit boundaries or on the IDLE->START transition, so it is glitch-free.
- Boundary conditions:
  - Full FIFO: can_push=0, and any push>0 is dropped.
  - Push and pop in the same cycle are both honoured.
  - Pointer wrap-around is handled by the FIFO. Byte order is preserved across wrap.
  - push=0 is a no-op.
- busy = (state != IDLE) | FIFO non-empty. It deasserts the cycle after the final STOP period ends with the FIFO empty.

Test Plan (clk_mhz=1, boadrate=100000, so scale=10, unless noted):
1. Reset, then push=1, data[0]=0x55 → tx low starts 2 cycles after push, then 10-cycle levels 0,1,0,1,0,1,0,1,0,1 (start, LSB-first, stop); busy=0 one cycle after the frame.
2. push=3 with bytes 0xA3,0x00,0xFF in one cycle → three frames back-to-back, in that order, 30*scale=300 cycles total, no idle cycle between stop and next start.
3. Fill to DEPTH=4 while transmitting, then push=2 → can_push=0 and request dropped; FIFO contents and count unchanged; the 4 queued bytes are sent unchanged.
4. With can_push=1, push=2 (bytes 0x11,0x22) → neither byte enqueued; a subsequent push=1 of 0x33 is the next byte sent.
5. Assert arstn low mid-DATA of 0x0F with 2 bytes queued → tx=1 immediately, busy=0, can_push=4; after release no frame appears until a new push.
6. Wrap test: push and drain 10 single bytes 0x00..0x09 interleaved → received order 0x00..0x09 with no loss.

Source files
------------

// File: rtl/uart_tx_module.sv
// uart_tx_module: transmit side of the board UART.
// Bytes arrive from result logic in bursts of up to N per cycle and are held
// in a small multi-push / single-pop FIFO. A bit-timing FSM drains the FIFO and
// serialises each byte as an 8N1 frame on tx.
//
// Handshake: a push of `push` bytes is taken only when push <= can_push, and
// then all of data[0..push-1] are enqueued in index order. When push > can_push,
// nothing is enqueued. can_push is computed from registered state, so a pop in
// the same cycle does not raise it until the following cycle.
//
// Ports (uart_tx_module):
//   clk        in   system clock, all logic on posedge
//   arstn      in   asynchronous active-low reset
//   data       in   [N-1:0][7:0] bytes to enqueue, data[0] sent first
//   push       in   number of bytes of data to enqueue this cycle (0..N)
//   can_push   out  min(free FIFO slots, N)
//   tx         out  registered serial line, idles high
//   busy       out  frame in progress or FIFO non-empty
//   fsm_state  out  current FSM state (0 idle, 1 start, 2 data, 3 stop)

// Circular FIFO that accepts up to NI words and releases up to NO words per cycle.
// Ports: wr_data/push/can_push on the write side, rd_data/pop/can_pop on the
// read side. rd_data[0] is the oldest entry. An over-sized push or pop is ignored.
module multi_push_multi_pop_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int NI    = 4,
   parameter int NO    = 1,
   localparam int IW   = $clog2(NI + 1),
   localparam int OW   = $clog2(NO + 1),
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                   clk,
   input  logic                   arstn,
   input  logic [NI-1:0][W-1:0]   wr_data,
   input  logic [IW-1:0]          push,
   output logic [IW-1:0]          can_push,
   output logic [NO-1:0][W-1:0]   rd_data,
   input  logic [OW-1:0]          pop,
   output logic [OW-1:0]          can_pop
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] free_slots;
   logic [IW-1:0] push_acc;
   logic [OW-1:0] pop_acc;

   // Offsets never exceed DEPTH, so one conditional subtract wraps the pointer
   // even when DEPTH is not a power of two.
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
      return AW'(s);
   endfunction

   assign free_slots = CW'(DEPTH) - count;
   assign can_push   = (free_slots > CW'(NI)) ? IW'(NI) : IW'(free_slots);
   assign can_pop    = (count > CW'(NO)) ? OW'(NO) : OW'(count);
   assign push_acc   = (push <= can_push) ? push : '0;
   assign pop_acc    = (pop <= can_pop) ? pop : '0;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wrap_add(wr_ptr, 32'(push_acc));
         rd_ptr <= wrap_add(rd_ptr, 32'(pop_acc));
         count  <= count + CW'(push_acc) - CW'(pop_acc);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (32'(push_acc) > 32'(i)) mem[wrap_add(wr_ptr, 32'(i))] <= wr_data[i];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int j = 0; j < NO; j++) rd_data[j] = mem[wrap_add(rd_ptr, 32'(j))];
   end

endmodule

module uart_tx_module #(
   parameter int clk_mhz  = 50,
   parameter int boadrate = 9600,
   parameter int DEPTH    = 4,
   parameter int N        = 4,
   localparam int PW      = $clog2(N + 1)
) (
   input  logic                clk,
   input  logic                arstn,
   input  logic [N-1:0][7:0]   data,
   input  logic [PW-1:0]       push,
   output logic [PW-1:0]       can_push,
   output logic                tx,
   output logic                busy,
   output logic [1:0]          fsm_state
);

   localparam int SCALE = clk_mhz * 1000 * 1000 / boadrate;
   localparam int CNTW  = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(SCALE - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

   state_t            state, state_d;
   logic [CNTW-1:0]   bit_cnt, cnt_d;
   logic [2:0]        bit_idx, idx_d;
   logic [7:0]        shift, shift_d;
   logic              tx_q, tx_d;
   logic [0:0]        pop;
   logic [0:0]        can_pop;
   logic [0:0][7:0]   fifo_rd;
   logic              fifo_has;
   logic              bit_end;

   multi_push_multi_pop_fifo #(.W(8), .DEPTH(DEPTH), .NI(N), .NO(1)) u_fifo (
      .clk      (clk),
      .arstn    (arstn),
      .wr_data  (data),
      .push     (push),
      .can_push (can_push),
      .rd_data  (fifo_rd),
      .pop      (pop),
      .can_pop  (can_pop)
   );

   assign fifo_has  = (can_pop != '0);
   assign bit_end   = (bit_cnt == '0);
   assign tx        = tx_q;
   assign busy      = (state != S_IDLE) | fifo_has;
   assign fsm_state = state;

   // State register; tx is registered here too so the line only moves on edges.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_d;
         bit_cnt <= cnt_d;
         bit_idx <= idx_d;
         shift   <= shift_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (fifo_has) state_d = S_START;
         S_START: if (bit_end) state_d = S_DATA;
         S_DATA:  if (bit_end && (bit_idx == 3'd7)) state_d = S_STOP;
         S_STOP:  if (bit_end) state_d = fifo_has ? S_START : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // tx_d is the level for the coming bit period; it changes only on a bit
   // boundary or when a byte is popped, which starts the start bit.
   always_comb begin
      pop     = 1'b0;
      cnt_d   = bit_cnt;
      idx_d   = bit_idx;
      shift_d = shift;
      tx_d    = tx_q;
      case (state)
         S_IDLE: begin
            tx_d = 1'b1;
            if (fifo_has) begin
               pop     = 1'b1;
               shift_d = fifo_rd[0];
               cnt_d   = CNT_MAX;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d = CNT_MAX;
               idx_d = 3'd0;
               tx_d  = shift[0];
            end else begin
               cnt_d = bit_cnt - 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = CNT_MAX;
               if (bit_idx == 3'd7) begin
                  tx_d = 1'b1;
               end else begin
                  idx_d = bit_idx + 3'd1;
                  tx_d  = shift[bit_idx + 3'd1];
               end
            end else begin
               cnt_d = bit_cnt - 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_d = CNT_MAX;
               if (fifo_has) begin
                  // Back-to-back frame: next start bit follows the stop bit directly.
                  pop     = 1'b1;
                  shift_d = fifo_rd[0];
                  tx_d    = 1'b0;
               end else begin
                  tx_d = 1'b1;
               end
            end else begin
               cnt_d = bit_cnt - 1'b1;
            end
         end
         default: begin
            tx_d = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module at 1 MHz / 100000 baud (10 cycles per bit).
// A frame-level model (queue of bytes plus position inside the current frame)
// predicts tx, busy and can_push after every edge; a line receiver rebuilds the
// transmitted bytes for comparison with hand-written byte lists.
module tb_uart_tx_module;

   localparam int CLK_MHZ = 1;
   localparam int BAUD    = 100000;
   localparam int SCALE   = CLK_MHZ * 1000 * 1000 / BAUD;
   localparam int DEPTH   = 4;
   localparam int N       = 4;

   logic           clk = 1'b0;
   logic           arstn = 1'b0;
   logic [3:0][7:0] data = '0;
   logic [2:0]     push = '0;
   logic [2:0]     can_push;
   logic           tx;
   logic           busy;
   logic [1:0]     fsm_state;

   int errors = 0;
   int checks = 0;

   uart_tx_module #(.clk_mhz(CLK_MHZ), .boadrate(BAUD), .DEPTH(DEPTH), .N(N)) dut (
      .clk       (clk),
      .arstn     (arstn),
      .data      (data),
      .push      (push),
      .can_push  (can_push),
      .tx        (tx),
      .busy      (busy),
      .fsm_state (fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   logic [7:0] mq[$];
   bit         m_act = 1'b0;
   int         m_pos = 0;
   logic [7:0] m_byte = '0;
   int         m_sz;
   int         m_cp;
   bit         m_pop;

   function automatic int model_can_push();
      int f;
      f = DEPTH - mq.size();
      return (f > N) ? N : f;
   endfunction

   // Level on the line at position m_pos of the current frame.
   function automatic logic model_tx();
      int b;
      if (!m_act) return 1'b1;
      b = m_pos / SCALE;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_byte[b-1];
   endfunction

   always @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         mq.delete();
         m_act = 1'b0;
         m_pos = 0;
      end else begin
         m_sz  = mq.size();
         m_cp  = model_can_push();
         m_pop = 1'b0;
         if (m_act) begin
            m_pos++;
            if (m_pos == 10 * SCALE) begin
               m_act = 1'b0;
               m_pop = (m_sz != 0);
            end
         end else begin
            m_pop = (m_sz != 0);
         end
         if (m_pop) begin
            m_byte = mq.pop_front();
            m_act  = 1'b1;
            m_pos  = 0;
         end
         if ((push != 0) && (int'(push) <= m_cp)) begin
            for (int i = 0; i < int'(push); i++) mq.push_back(data[i]);
         end
      end
   end

   // one compare process, every cycle
   always @(negedge clk) begin
      check("cyc_tx", tx, model_tx());
      check("cyc_busy", busy, (m_act || mq.size() != 0) ? 1 : 0);
      check("cyc_can_push", can_push, model_can_push());
   end

   // ---------------- line receiver ----------------
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   bit         rx_act = 1'b0;
   int         rx_cnt = 0;
   int         rx_b;
   logic [7:0] rx_sh = '0;

   always @(negedge clk) begin
      if (!arstn) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (tx == 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % SCALE == SCALE / 2) begin
            rx_b = rx_cnt / SCALE;
            if (rx_b >= 1 && rx_b <= 8) begin
               rx_sh[rx_b-1] = tx;
            end else if (rx_b == 9) begin
               rx_act = 1'b0;
               check("rx_stop_bit", tx, 1);
               rx_q.push_back(rx_sh);
            end
         end
      end
   end

   task automatic check_rx(input string name);
      check({name, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check({name, "_byte"}, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a negedge; returns just after the negedge following the push edge.
   task automatic do_push(input logic [2:0] n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
      data = {b3, b2, b1, b0};
      push = n;
      @(posedge clk);
      #1;
      push = '0;
      @(negedge clk);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string name, input int maxc, output int n);
      n = 0;
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle_timeout"}, busy, 0);
   endtask

   // ---------------- directed tests ----------------
   int n_cyc;
   logic [9:0] lv;

   initial begin
      step(3);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_can_push", can_push, 4);
      arstn = 1'b1;
      step(2);

      // push=0 is a no-op
      data = 32'hEEEEEEEE;
      push = 3'd0;
      step(2);
      check("nop_busy", busy, 0);
      check("nop_tx", tx, 1);

      // T1: single 0x55 frame, literal waveform
      do_push(3'd1, 8'h55, 8'h00, 8'h00, 8'h00);
      check("t1_tx_before_pop", tx, 1);
      check("t1_busy", busy, 1);
      lv = 10'b1010101010;
      for (int i = 0; i < 10 * SCALE; i++) begin
         @(negedge clk);
         check("t1_wave", tx, lv[i / SCALE]);
      end
      @(negedge clk);
      check("t1_busy_after", busy, 0);
      check("t1_tx_after", tx, 1);
      exp_q = '{8'h55};
      check_rx("t1_rx");

      // T2: three bytes in one push, back-to-back frames
      do_push(3'd3, 8'hA3, 8'h00, 8'hFF, 8'h00);
      check("t2_can_push", can_push, 1);
      wait_idle("t2", 400, n_cyc);
      check("t2_len", n_cyc, 301);
      exp_q = '{8'hA3, 8'h00, 8'hFF};
      check_rx("t2_rx");

      // T3: fill to DEPTH while transmitting, then an over-sized push is dropped
      do_push(3'd1, 8'h10, 8'h00, 8'h00, 8'h00);
      step(1);
      do_push(3'd4, 8'h21, 8'h22, 8'h23, 8'h24);
      check("t3_full", can_push, 0);
      do_push(3'd2, 8'h77, 8'h88, 8'h00, 8'h00);
      check("t3_full_after_drop", can_push, 0);
      wait_idle("t3", 700, n_cyc);
      exp_q = '{8'h10, 8'h21, 8'h22, 8'h23, 8'h24};
      check_rx("t3_rx");

      // T4: can_push=1, push=2 dropped, then push=1 accepted
      do_push(3'd1, 8'h40, 8'h00, 8'h00, 8'h00);
      step(1);
      do_push(3'd3, 8'h41, 8'h42, 8'h43, 8'h00);
      check("t4_can_push_one", can_push, 1);
      do_push(3'd2, 8'h11, 8'h22, 8'h00, 8'h00);
      check("t4_after_drop", can_push, 1);
      do_push(3'd1, 8'h33, 8'h00, 8'h00, 8'h00);
      check("t4_after_one", can_push, 0);
      wait_idle("t4", 700, n_cyc);
      exp_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h33};
      check_rx("t4_rx");

      // T5: reset mid-DATA of 0x0F with two bytes queued
      do_push(3'd1, 8'h0F, 8'h00, 8'h00, 8'h00);
      step(1);
      do_push(3'd2, 8'hAA, 8'hBB, 8'h00, 8'h00);
      step(25);
      #2;
      arstn = 1'b0;
      #1;
      check("t5_rst_tx", tx, 1);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_can_push", can_push, 4);
      step(3);
      arstn = 1'b1;
      rx_q.delete();
      step(200);
      check("t5_no_frame", rx_q.size(), 0);
      check("t5_idle_busy", busy, 0);
      rx_q.delete();

      // T6: ten single bytes interleaved with draining, pointers wrap
      for (int v = 0; v < 10; v++) begin
         do_push(3'd1, 8'(v), 8'h00, 8'h00, 8'h00);
         step(69);
      end
      wait_idle("t6", 1200, n_cyc);
      for (int v = 0; v < 10; v++) exp_q.push_back(8'(v));
      check_rx("t6_rx");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
